fetch_stage: RTL

//  Instruction-fetch stage directly upstream of the segmented memory's instruction port.

---
 rtl/fetch_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC ownership, branch redirect, start/halt gating, perf counters
module fetch_stage #(
    parameter int                WIDTH            = 32,
    parameter int                INSTRUCTIONWIDTH = 24,
    parameter logic [WIDTH-1:0]  RESET_PC         = '0,
    parameter int                PC_INC           = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        halt_i,
    input  logic                        stall_i,
    input  logic                        branch_i,
    input  logic [WIDTH-1:0]            branch_target_i,
    output logic [WIDTH-1:0]            imem_addr_o,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata_i,
    output logic                        valid_o,
    output logic [INSTRUCTIONWIDTH-1:0] instr_o,
    output logic [WIDTH-1:0]            pc_o,
    output logic [WIDTH-1:0]            fetch_count_o,
    output logic [WIDTH-1:0]            stall_count_o
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] req_pc_q;
    logic [WIDTH-1:0] fetch_count_q;
    logic [WIDTH-1:0] stall_count_q;
    logic [WIDTH-1:0] next_addr;
    logic             valid;
    logic             accept;
    logic             stall_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only start leaves IDLE/HALTED, only halt leaves RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_i) begin
                    state_d = HALTED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/address decode; the kill of valid by halt/branch is deliberately combinational
    always_comb begin
        valid     = 1'b0;
        next_addr = req_pc_q;
        if (state_q == RUN) begin
            if (halt_i) begin
                next_addr = req_pc_q;
            end else if (branch_i) begin
                next_addr = branch_target_i;
            end else if (stall_i) begin
                valid     = 1'b1;
                next_addr = req_pc_q;
            end else begin
                valid     = 1'b1;
                next_addr = req_pc_q + PC_STEP;
            end
        end
        accept    = valid & ~stall_i;
        stall_hit = valid & stall_i;
    end

    // Request PC always tracks the address presented last cycle, i.e. the PC of imem_rdata_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q <= RESET_PC;
        end else begin
            req_pc_q <= next_addr;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (accept && (fetch_count_q != '1)) begin
                fetch_count_q <= fetch_count_q + CNT_ONE;
            end
            if (stall_hit && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_ONE;
            end
        end
    end

    assign imem_addr_o   = next_addr;
    assign valid_o       = valid;
    assign instr_o       = valid ? imem_rdata_i : '0;
    assign pc_o          = req_pc_q;
    assign fetch_count_o = fetch_count_q;
    assign stall_count_o = stall_count_q;

endmodule
